dm_port_arbiter: RTL and testbench

//  Shares the single-port data-memory BRAM between two requesters: the CPU memory-access (MA) stage and an

---
 rtl/dm_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//   Shares the single-port data-memory BRAM between the CPU memory-access
//   stage and an external loader/debug port. Accesses are serialised by a
//   small FSM (IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE). cpu_done doubles as
//   the DMdone stall-release pulse for the CPU pipeline.
//
//   Build option: DMARB_FIXED_PRIO_EN
//     defined     - CPU always wins a tie; EXT is served only when cpu_req
//                   is low in IDLE.
//     not defined - round-robin between the two requesters.
//
// Ports
//   clk, rst                       clock; asynchronous active-low reset
//   cpu_req/we/addr/wdata          CPU request side (held until cpu_done)
//   cpu_rdata, cpu_done            CPU read data (held) and completion pulse
//   ext_req/we/addr/wdata          external port request side
//   ext_rdata, ext_done            external port read data and completion
//   mem_clka/ena/wea/addra/dina    BRAM port A control and write data
//   mem_douta                      BRAM read data
//   busy                           high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_done,
  output logic              mem_clka,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LATENCY - 1);

  state_t              state, state_nxt;
  logic                grant_ext;   // 1 = current access belongs to EXT
  logic                pick_ext;    // arbitration result while in IDLE
  logic                any_req;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [CNT_W-1:0]    wait_cnt;

`ifndef DMARB_FIXED_PRIO_EN
  logic                last_ext;    // 1 = EXT got the most recent grant
`endif

  assign mem_clka = clk;
  assign any_req  = cpu_req | ext_req;

  // Winner selection; only consumed in IDLE.
  always_comb begin
`ifdef DMARB_FIXED_PRIO_EN
    pick_ext = ~cpu_req;
`else
    pick_ext = ext_req & (~cpu_req | ~last_ext);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = lat_we ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_ext <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
`ifndef DMARB_FIXED_PRIO_EN
      last_ext  <= 1'b1;   // CPU wins the first tie after reset
`endif
    end else begin
      if (state == S_IDLE && any_req) begin
        grant_ext <= pick_ext;
`ifndef DMARB_FIXED_PRIO_EN
        last_ext  <= pick_ext;
`endif
        lat_we    <= pick_ext ? ext_we    : cpu_we;
        lat_addr  <= pick_ext ? ext_addr  : cpu_addr;
        lat_wdata <= pick_ext ? ext_wdata : cpu_wdata;
      end

      if (state == S_ISSUE)
        wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - CNT_W'(1);

      // Last WAIT cycle: read data is valid, capture into the owner's register.
      if (state == S_WAIT && wait_cnt == '0) begin
        if (grant_ext) ext_rdata <= mem_douta;
        else           cpu_rdata <= mem_douta;
      end
    end
  end

  always_comb begin
    mem_ena   = (state == S_ISSUE) || (state == S_WAIT);
    mem_wea   = (state == S_ISSUE) && lat_we;
    mem_addra = lat_addr;
    mem_dina  = lat_wdata;
    cpu_done  = (state == S_RESP) && !grant_ext;
    ext_done  = (state == S_RESP) &&  grant_ext;
    busy      = (state != S_IDLE);
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
//   Directed and randomised bench for dm_port_arbiter. A BRAM model with a
//   RD_LATENCY-deep read pipeline sits behind the DUT. The reference model
//   works at transaction level: when the arbiter is free it picks a winner,
//   derives the completion cycle from the access type and tracks expected
//   memory contents and per-port read data.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;
  localparam int AW  = 7;
  localparam int DW  = 32;
  localparam int RDL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_d   [2];
  logic          we_d    [2];
  logic [AW-1:0] addr_d  [2];
  logic [DW-1:0] wdata_d [2];
  logic [DW-1:0] cpu_rdata, ext_rdata, mem_dina, mem_douta;
  logic          cpu_done, ext_done, mem_clka, mem_ena, mem_wea, busy;
  logic [AW-1:0] mem_addra;

  dm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(req_d[0]), .cpu_we(we_d[0]), .cpu_addr(addr_d[0]), .cpu_wdata(wdata_d[0]),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .ext_req(req_d[1]), .ext_we(we_d[1]), .ext_addr(addr_d[1]), .ext_wdata(wdata_d[1]),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_clka(mem_clka), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_douta(mem_douta),
    .busy(busy)
  );

  // ---------------- BRAM model ----------------
  logic [DW-1:0] bram    [2**AW];
  bit            bram_wr [2**AW];
  logic [DW-1:0] pipe    [RDL];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return (DW'(a) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_ena && mem_wea) begin
      bram[mem_addra]    <= mem_dina;
      bram_wr[mem_addra] <= 1'b1;
    end
    pipe[0] <= bram_wr[mem_addra] ? bram[mem_addra] : init_word(mem_addra);
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_douta = pipe[RDL-1];

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    gap;
  } txn_t;

  txn_t          txq0[$], txq1[$];
  txn_t          cur [2];
  bit            pend[2];
  logic [DW-1:0] shadow [2**AW];
  logic [DW-1:0] exp_rd [2];
  bit            act;
  int unsigned   g, last_g, grant_t, done_at, next_free, cyc;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_data, g_val;
  int unsigned   obs_order[$];
  int unsigned   done_cyc[2];
  int unsigned   exp_seq[4];
  int            n_checks, n_errors;

  task automatic chk(input logic [DW-1:0] obs, input logic [DW-1:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned p, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [7:0] gp);
    txn_t t;
    t.we = we; t.addr = a; t.data = d; t.gap = gp;
    if (p == 0) txq0.push_back(t); else txq1.push_back(t);
  endtask

  task automatic push_rand(input int unsigned p);
    push(p, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, 8'($urandom_range(0, 3)));
  endtask

  task automatic model_reset();
    act = 0; last_g = 1; next_free = 0;
    for (int p = 0; p < 2; p++) begin
      exp_rd[p] = '0; pend[p] = 0; req_d[p] = 1'b0;
    end
  endtask

  task automatic try_raise(input int unsigned p);
    txn_t t;
    if (p == 0) begin
      if (txq0.size() == 0) return;
      t = txq0.pop_front();
      if (t.gap != 0) begin t.gap--; txq0.push_front(t); return; end
    end else begin
      if (txq1.size() == 0) return;
      t = txq1.pop_front();
      if (t.gap != 0) begin t.gap--; txq1.push_front(t); return; end
    end
    cur[p] = t; pend[p] = 1;
    req_d[p] = 1'b1; we_d[p] = t.we; addr_d[p] = t.addr; wdata_d[p] = t.data;
  endtask

  // One cycle: check outputs against the model, update drivers, arbitrate.
  task automatic step();
    bit          e_done0, e_done1, e_busy, e_ena, e_wea;
    int unsigned w;
    @(negedge clk);
    cyc++;
    if (act && cyc == done_at && !g_we) exp_rd[g] = g_val;
    e_done0 = act && cyc == done_at && g == 0;
    e_done1 = act && cyc == done_at && g == 1;
    e_busy  = act && cyc > grant_t && cyc <= done_at;
    e_ena   = act && cyc > grant_t && cyc < done_at;
    e_wea   = act && g_we && cyc == grant_t + 1;
    chk(32'(cpu_done), 32'(e_done0), "cpu_done");
    chk(32'(ext_done), 32'(e_done1), "ext_done");
    chk(32'(busy),     32'(e_busy),  "busy");
    chk(32'(mem_ena),  32'(e_ena),   "mem_ena");
    chk(32'(mem_wea),  32'(e_wea),   "mem_wea");
    chk(32'(mem_clka), 32'(clk),     "mem_clka");
    if (e_ena) chk(32'(mem_addra), 32'(g_addr), "mem_addra");
    if (e_wea) chk(mem_dina, g_data, "mem_dina");
    chk(cpu_rdata, exp_rd[0], "cpu_rdata");
    chk(ext_rdata, exp_rd[1], "ext_rdata");
    if (cpu_done) begin obs_order.push_back(0); done_cyc[0] = cyc; end
    if (ext_done) begin obs_order.push_back(1); done_cyc[1] = cyc; end

    if (act && cyc == done_at) begin
      act = 0; pend[g] = 0; req_d[g] = 1'b0;
    end
    // Address/data of the granted port may wander after the latch edge.
    if (act && cyc > grant_t) begin
      addr_d[g]  = AW'($urandom);
      wdata_d[g] = $urandom;
    end
    for (int p = 0; p < 2; p++) if (!pend[p]) try_raise(p);

    if (!act && cyc >= next_free && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) begin
`ifdef DMARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (last_g == 0) ? 1 : 0;
`endif
      end else begin
        w = pend[0] ? 0 : 1;
      end
      last_g = w; act = 1; g = w; grant_t = cyc;
      g_we = cur[w].we; g_addr = cur[w].addr; g_data = cur[w].data;
      done_at   = cyc + (g_we ? 2 : RDL + 2);
      next_free = done_at + 1;
      if (g_we) shadow[g_addr] = g_data;
      else      g_val = shadow[g_addr];
    end
  endtask

  task automatic drain(input int unsigned max_cyc, input string tag);
    int unsigned n = 0;
    while ((txq0.size() != 0 || txq1.size() != 0 || pend[0] || pend[1] || act) && n < max_cyc) begin
      step();
      n++;
    end
    n_checks++;
    assert (n < max_cyc) else begin
      n_errors++;
      $error("FAIL %s_timeout: observed %0d cycles expected fewer than %0d", tag, n, max_cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk(32'(busy), 0, {tag, "_busy"});
    chk(32'(mem_ena), 0, {tag, "_ena"});
    chk(32'(mem_wea), 0, {tag, "_wea"});
    chk(32'(mem_addra), 0, {tag, "_addra"});
    chk(mem_dina, '0, {tag, "_dina"});
    chk(32'(cpu_done), 0, {tag, "_cpu_done"});
    chk(32'(ext_done), 0, {tag, "_ext_done"});
    chk(cpu_rdata, '0, {tag, "_cpu_rdata"});
    chk(ext_rdata, '0, {tag, "_ext_rdata"});
  endtask

  // Asserts reset at the current time, checks outputs, releases at a negedge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    model_reset();
    #1 check_zero(tag);
    repeat (2) begin
      @(negedge clk);
      chk(32'(cpu_done), 0, {tag, "_hold_cpu_done"});
      chk(32'(busy), 0, {tag, "_hold_busy"});
    end
    rst = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] saved;
    int unsigned   n;
    n_checks = 0; n_errors = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      we_d[i] = 1'b0; addr_d[i] = '0; wdata_d[i] = '0;
    end
    for (int unsigned a = 0; a < 2**AW; a++) shadow[a] = init_word(AW'(a));
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // 1: CPU write then read of 0x05
    push(0, 1'b1, 7'h05, 32'hDEADBEEF, 8'd0);
    push(0, 1'b0, 7'h05, 32'h0, 8'd0);
    drain(40, "t1");
    chk(cpu_rdata, 32'hDEADBEEF, "t1_rdata");

    // 2: simultaneous reads after reset, CPU first
    @(negedge clk);
    do_reset("rst2");
    obs_order.delete();
    push(0, 1'b0, 7'h10, 32'h0, 8'd0);
    push(1, 1'b0, 7'h11, 32'h0, 8'd0);
    drain(40, "t2");
    chk(32'(obs_order.size()), 2, "t2_count");
    if (obs_order.size() == 2) begin
      chk(32'(obs_order[0]), 0, "t2_first");
      chk(32'(obs_order[1]), 1, "t2_second");
      chk(32'(done_cyc[1] - done_cyc[0]), 32'(RDL + 3), "t2_gap");
    end

    // 3: both held continuously for 4 accesses
    obs_order.delete();
    for (int i = 0; i < 2; i++) begin
      push(0, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, 8'd0);
      push(1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, 8'd0);
    end
`ifdef DMARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 1, 1};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    drain(60, "t3");
    chk(32'(obs_order.size()), 4, "t3_count");
    if (obs_order.size() == 4)
      for (int i = 0; i < 4; i++) chk(32'(obs_order[i]), 32'(exp_seq[i]), "t3_order");

    // 4: EXT write/read of the top address; CPU read data untouched
    saved = exp_rd[0];
    push(1, 1'b1, 7'h7F, 32'h12345678, 8'd0);
    push(1, 1'b0, 7'h7F, 32'h0, 8'd0);
    drain(40, "t4");
    chk(ext_rdata, 32'h12345678, "t4_ext_rdata");
    chk(cpu_rdata, saved, "t4_cpu_rdata");

    // 5: reset during WAIT of a CPU read, then re-issue
    push(0, 1'b0, 7'h22, 32'h0, 8'd0);
    n = 0;
    while (!(act && cyc == grant_t + 2) && n < 20) begin step(); n++; end
    n_checks++;
    assert (n < 20) else begin
      n_errors++;
      $error("FAIL t5_reach_wait: observed %0d cycles expected fewer than 20", n);
    end
    do_reset("t5_rst");
    push(0, 1'b0, 7'h22, 32'h0, 8'd0);
    drain(40, "t5");
    chk(cpu_rdata, shadow[7'h22], "t5_rdata");

    // Randomised traffic on both ports
    for (int i = 0; i < 30; i++) begin
      push_rand(0);
      push_rand(1);
    end
    drain(3000, "rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
